mine_planter: RTL and testbench

MINE_PLANTER -- requirements
Module: mine_planter

---
 rtl/mine_planter_if.sv | 28 ++
 rtl/mine_planter.sv | 188 ++++++++++++++++++
 tb/tb_mine_planter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mine_planter_if.sv
// Game-wide encodings and the Wishbone bus interface shared by the game blocks.
package game_pkg;
  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;

  typedef enum logic [2:0] {
    MENU = 3'd0,
    PLAY = 3'd1,
    WIN  = 3'd2,
    LOSE = 3'd3
  } main_state_t;
endpackage

interface wishbone_if;
  logic                          cyc_o;
  logic                          stb_o;
  logic                          we_o;
  logic [game_pkg::WB_ADR_W-1:0] adr_o;
  logic [game_pkg::WB_DAT_W-1:0] dat_o;
  logic [game_pkg::WB_DAT_W-1:0] dat_i;
  logic                          ack_i;
  logic                          stall_i;

  modport master (output cyc_o, stb_o, we_o, adr_o, dat_o,
                  input  dat_i, ack_i, stall_i);
  modport slave  (input  cyc_o, stb_o, we_o, adr_o, dat_o,
                  output dat_i, ack_i, stall_i);
endinterface

// File: rtl/mine_planter.sv
// Reads board size and mine count, plants mines in a 16x16 bitmap using an
// LFSR with a deterministic fallback scan, then writes the board out cell by cell.
module mine_planter
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_state,
  wishbone_if.master game_set_wb,
  wishbone_if.master game_board_wb
);
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    READ_SETTINGS = 3'd1,
    PLANT         = 3'd2,
    WRITE_BOARD   = 3'd3,
    DONE          = 3'd4
  } planter_state_t;

  localparam logic [5:0]  RANDOM_CYCLES = 6'd48;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;

  planter_state_t planter_state, state_d;

  logic [15:0]  lfsr;
  logic [255:0] mines;
  logic [255:0] in_range;
  logic [4:0]   n_q;
  logic [7:0]   m_q;
  logic [7:0]   placed_q;
  logic [5:0]   cand_q;
  logic         rd_second_q;
  logic         set_stb_q;
  logic [7:0]   set_adr_q;
  logic         brd_stb_q;
  logic [7:0]   brd_adr_q;
  logic         brd_dat_q;

  logic       in_play, set_ack, brd_ack, last_cell, place;
  logic [7:0] place_idx, set_dat8;
  logic [4:0] n_clamp, n_m1;
  logic [9:0] n_sq, m_max;
  logic [7:0] m_clamp;
  logic       unused_bits;

  assign in_play  = (main_state == PLAY);
  assign set_ack  = set_stb_q && game_set_wb.ack_i && !game_set_wb.stall_i;
  assign brd_ack  = brd_stb_q && game_board_wb.ack_i && !game_board_wb.stall_i;
  assign set_dat8 = game_set_wb.dat_i[7:0];

  assign n_clamp = (set_dat8 == 8'd0) ? 5'd1 :
                   (set_dat8 > 8'd16) ? 5'd16 : set_dat8[4:0];
  assign n_sq    = n_q * n_q;
  assign m_max   = n_sq - 10'd1;
  assign m_clamp = ({2'b00, set_dat8} > m_max) ? m_max[7:0] : set_dat8;
  assign n_m1    = n_q - 5'd1;
  assign last_cell = (brd_adr_q[7:4] == n_m1[3:0]) && (brd_adr_q[3:0] == n_m1[3:0]);

  always_comb begin
    in_range = '0;
    for (int unsigned i = 0; i < 256; i++) begin
      in_range[i] = (5'(i >> 4) < n_q) && (5'(i & 15) < n_q);
    end
  end

  // Random phase tries the LFSR cell; afterwards take the lowest free in-range cell.
  always_comb begin
    place     = 1'b0;
    place_idx = lfsr[7:0];
    if (planter_state == PLANT && in_play && placed_q != m_q) begin
      if (cand_q < RANDOM_CYCLES) begin
        place = in_range[lfsr[7:0]] && !mines[lfsr[7:0]];
      end else begin
        for (int unsigned i = 0; i < 256; i++) begin
          if (!place && in_range[i] && !mines[i]) begin
            place     = 1'b1;
            place_idx = 8'(i);
          end
        end
      end
    end
  end

  always_comb begin
    state_d = planter_state;
    case (planter_state)
      IDLE:          if (in_play) state_d = READ_SETTINGS;
      READ_SETTINGS: begin
        if (set_ack) begin
          if (!in_play)         state_d = IDLE;
          else if (rd_second_q) state_d = PLANT;
        end else if (!in_play && !set_stb_q) begin
          state_d = IDLE;
        end
      end
      PLANT: begin
        if (!in_play)              state_d = IDLE;
        else if (placed_q == m_q)  state_d = WRITE_BOARD;
      end
      WRITE_BOARD: begin
        if (brd_ack) begin
          if (!in_play)       state_d = IDLE;
          else if (last_cell) state_d = DONE;
        end else if (!in_play && !brd_stb_q) begin
          state_d = IDLE;
        end
      end
      DONE:    if (!in_play) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      planter_state <= IDLE;
      lfsr          <= LFSR_SEED;
      mines         <= '0;
      n_q           <= '0;
      m_q           <= '0;
      placed_q      <= '0;
      cand_q        <= '0;
      rd_second_q   <= 1'b0;
      set_stb_q     <= 1'b0;
      set_adr_q     <= '0;
      brd_stb_q     <= 1'b0;
      brd_adr_q     <= '0;
      brd_dat_q     <= 1'b0;
    end else begin
      planter_state <= state_d;
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (planter_state)
        IDLE: rd_second_q <= 1'b0;
        READ_SETTINGS: begin
          if (set_ack) begin
            set_stb_q <= 1'b0;
            if (!rd_second_q) begin
              n_q         <= n_clamp;
              rd_second_q <= 1'b1;
            end else begin
              m_q      <= m_clamp;
              mines    <= '0;
              placed_q <= '0;
              cand_q   <= '0;
            end
          end else if (!set_stb_q && in_play) begin
            set_stb_q <= 1'b1;
            set_adr_q <= rd_second_q ? 8'd2 : 8'd1;
          end
        end
        PLANT: begin
          if (place) begin
            mines[place_idx] <= 1'b1;
            placed_q         <= placed_q + 8'd1;
          end
          if (cand_q < RANDOM_CYCLES && placed_q != m_q) cand_q <= cand_q + 6'd1;
          brd_adr_q <= '0;
        end
        WRITE_BOARD: begin
          // The cursor only moves on acceptance, so stalls never disturb adr/dat.
          if (brd_ack) begin
            brd_stb_q <= 1'b0;
            if (brd_adr_q[3:0] == n_m1[3:0]) brd_adr_q <= {brd_adr_q[7:4] + 4'd1, 4'd0};
            else                             brd_adr_q <= brd_adr_q + 8'd1;
          end else if (!brd_stb_q && in_play) begin
            brd_stb_q <= 1'b1;
            brd_dat_q <= mines[brd_adr_q];
          end
        end
        default: ;
      endcase
    end
  end

  assign game_set_wb.cyc_o = set_stb_q;
  assign game_set_wb.stb_o = set_stb_q;
  assign game_set_wb.we_o  = 1'b0;
  assign game_set_wb.adr_o = {{(WB_ADR_W-8){1'b0}}, set_adr_q};
  assign game_set_wb.dat_o = '0;

  assign game_board_wb.cyc_o = brd_stb_q;
  assign game_board_wb.stb_o = brd_stb_q;
  assign game_board_wb.we_o  = brd_stb_q;
  assign game_board_wb.adr_o = {{(WB_ADR_W-8){1'b0}}, brd_adr_q};
  assign game_board_wb.dat_o = {{(WB_DAT_W-1){1'b0}}, brd_dat_q};

  assign unused_bits = ^{game_set_wb.dat_i[WB_DAT_W-1:8], game_board_wb.dat_i,
                         m_max[9:8], n_m1[4]};
endmodule

// File: tb/tb_mine_planter.sv
// Directed bench for mine_planter with a board-write scoreboard and an auto-acking board slave.
module tb_mine_planter;
  import game_pkg::*;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_PLANT = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] main_state = 3'd0;

  wishbone_if set_bus();
  wishbone_if brd_bus();

  mine_planter dut (
    .clk          (clk),
    .rst          (rst),
    .main_state   (main_state),
    .game_set_wb  (set_bus),
    .game_board_wb(brd_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int mine_total = 0;
  bit resp_en = 1'b0;
  bit stall_mode = 1'b0;
  logic [7:0] exp_wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int bound, input string tag);
    int cyc = 0;
    while (dut.planter_state !== target && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, 32'(dut.planter_state), 32'(target));
  endtask

  task automatic serve_read(input logic [7:0] adr, input logic [7:0] data,
                            input int stall_cycles, input string tag);
    int cyc = 0;
    while (!set_bus.stb_o && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_rd_stb"}, 32'(set_bus.stb_o), 1);
    check({tag, "_rd_cyc"}, 32'(set_bus.cyc_o), 1);
    check({tag, "_rd_we"}, 32'(set_bus.we_o), 0);
    check({tag, "_rd_adr"}, set_bus.adr_o, 32'(adr));
    set_bus.dat_i = 32'(data);
    repeat (stall_cycles) begin
      set_bus.ack_i = 1'b1;
      set_bus.stall_i = 1'b1;
      @(posedge clk); #1;
      check({tag, "_rd_stall_stb"}, 32'(set_bus.stb_o), 1);
      check({tag, "_rd_stall_adr"}, set_bus.adr_o, 32'(adr));
    end
    set_bus.stall_i = 1'b0;
    set_bus.ack_i = 1'b1;
    @(posedge clk); #1;
    set_bus.ack_i = 1'b0;
    set_bus.dat_i = '0;
  endtask

  task automatic push_board(input int n);
    exp_wr_q.delete();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        exp_wr_q.push_back(8'(r * 16 + c));
  endtask

  task automatic run_game(input int n_raw, input int m_raw, input bit stalls, input string tag);
    int n_exp, m_exp, wr0, mn0;
    n_exp = (n_raw == 0) ? 1 : (n_raw > 16) ? 16 : n_raw;
    m_exp = (m_raw > n_exp * n_exp - 1) ? n_exp * n_exp - 1 : m_raw;
    push_board(n_exp);
    wr0 = wr_total;
    mn0 = mine_total;
    stall_mode = stalls;
    resp_en = 1'b1;
    main_state = PLAY;
    serve_read(8'd1, 8'(n_raw), stalls ? 2 : 0, tag);
    serve_read(8'd2, 8'(m_raw), 0, tag);
    wait_state(S_PLANT, 4, {tag, "_plant_entry"});
    wait_state(S_WRITE, 90, {tag, "_plant_len"});
    wait_state(S_DONE, 1300, {tag, "_done"});
    check({tag, "_writes"}, 32'(wr_total - wr0), 32'(n_exp * n_exp));
    check({tag, "_mines"}, 32'(mine_total - mn0), 32'(m_exp));
    check({tag, "_sb_left"}, 32'(exp_wr_q.size()), 0);
    main_state = MENU;
    wait_state(S_IDLE, 4, {tag, "_back_idle"});
    stall_mode = 1'b0;
  endtask

  // Board slave: acks any strobe one step after it appears, optionally with random stalls.
  initial begin
    brd_bus.ack_i = 1'b0;
    brd_bus.stall_i = 1'b0;
    brd_bus.dat_i = '0;
    forever begin
      @(posedge clk); #1;
      brd_bus.stall_i = stall_mode && ($urandom_range(0, 2) == 0);
      brd_bus.ack_i = resp_en && brd_bus.stb_o;
    end
  end

  // Write monitor: scoreboard pop on each accepted transfer, hold check across stalls.
  initial begin
    logic pend;
    logic [31:0] padr, pdat;
    logic [7:0] e;
    pend = 1'b0;
    padr = '0;
    pdat = '0;
    forever begin
      @(negedge clk);
      if (pend && brd_bus.stb_o) begin
        check("stall_adr_hold", brd_bus.adr_o, padr);
        check("stall_dat_hold", brd_bus.dat_o, pdat);
      end
      if (brd_bus.stb_o && brd_bus.ack_i && !brd_bus.stall_i) begin
        check("wr_we", 32'(brd_bus.we_o), 1);
        check("wr_dat_hi", brd_bus.dat_o >> 1, 0);
        check("wr_expected", 32'(exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          check("wr_adr", brd_bus.adr_o, 32'(e));
        end
        wr_total++;
        if (brd_bus.dat_o[0]) mine_total++;
        pend = 1'b0;
      end else begin
        pend = brd_bus.stb_o;
      end
      padr = brd_bus.adr_o;
      pdat = brd_bus.dat_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr0, mn0, stb_seen;
    set_bus.ack_i = 1'b0;
    set_bus.stall_i = 1'b0;
    set_bus.dat_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dut.planter_state), 32'(S_IDLE));
    check("rst_set_stb", 32'(set_bus.stb_o), 0);
    check("rst_set_cyc", 32'(set_bus.cyc_o), 0);
    check("rst_set_adr", set_bus.adr_o, 0);
    check("rst_brd_stb", 32'(brd_bus.stb_o), 0);
    check("rst_brd_we", 32'(brd_bus.we_o), 0);
    check("rst_brd_adr", brd_bus.adr_o, 0);
    check("rst_brd_dat", brd_bus.dat_o, 0);
    @(negedge clk) rst = 1'b1;

    // Full 16x16 game with 40 mines, cycle-exact read handshakes
    push_board(16);
    wr0 = wr_total;
    mn0 = mine_total;
    resp_en = 1'b1;
    @(posedge clk); #1;
    main_state = PLAY;
    repeat (2) @(posedge clk);
    #1;
    check("g16_rd1_stb", 32'(set_bus.stb_o), 1);
    check("g16_rd1_adr", set_bus.adr_o, 1);
    set_bus.dat_i = 32'd16;
    set_bus.ack_i = 1'b1;
    @(posedge clk); #1;
    set_bus.ack_i = 1'b0;
    check("g16_gap_stb", 32'(set_bus.stb_o), 0);
    repeat (2) @(posedge clk);
    #1;
    check("g16_rd2_stb", 32'(set_bus.stb_o), 1);
    check("g16_rd2_adr", set_bus.adr_o, 2);
    set_bus.dat_i = 32'd40;
    set_bus.ack_i = 1'b1;
    @(posedge clk); #1;
    set_bus.ack_i = 1'b0;
    set_bus.dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("g16_plant", 32'(dut.planter_state), 32'(S_PLANT));
    repeat (100) @(posedge clk);
    #1;
    check("g16_write", 32'(dut.planter_state), 32'(S_WRITE));
    wait_state(S_DONE, 1300, "g16_done");
    check("g16_writes", 32'(wr_total - wr0), 256);
    check("g16_mines", 32'(mine_total - mn0), 40);
    check("g16_sb_left", 32'(exp_wr_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    check("g16_done_hold", 32'(dut.planter_state), 32'(S_DONE));
    check("g16_done_idle_bus", 32'(brd_bus.stb_o | set_bus.stb_o), 0);
    main_state = MENU;
    wait_state(S_IDLE, 4, "g16_back_idle");

    // Dense, stalled and clamped configurations
    run_game(4, 15, 1'b0, "g4");
    run_game(4, 15, 1'b1, "g4s");
    run_game(0, 5, 1'b0, "n0");
    run_game(2, 9, 1'b0, "m9");
    run_game(17, 3, 1'b0, "n17");

    // Leaving PLAY mid-write completes the in-flight transfer only
    push_board(4);
    main_state = PLAY;
    serve_read(8'd1, 8'd4, 0, "ab");
    serve_read(8'd2, 8'd3, 0, "ab");
    wait_state(S_WRITE, 100, "ab_write");
    repeat (3) @(posedge clk);
    #1;
    stb_seen = 0;
    while (!brd_bus.stb_o && stb_seen < 10) begin
      @(posedge clk); #1;
      stb_seen++;
    end
    check("ab_inflight_stb", 32'(brd_bus.stb_o), 1);
    wr0 = wr_total;
    main_state = MENU;
    wait_state(S_IDLE, 5, "ab_idle");
    check("ab_inflight_done", 32'(wr_total - wr0), 1);
    stb_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (brd_bus.stb_o || set_bus.stb_o) stb_seen++;
    end
    check("ab_no_stb", 32'(stb_seen), 0);
    exp_wr_q.delete();

    // Reset asserted during PLANT
    main_state = PLAY;
    serve_read(8'd1, 8'd16, 0, "rp");
    serve_read(8'd2, 8'd40, 0, "rp");
    wait_state(S_PLANT, 4, "rp_plant");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rp_state", 32'(dut.planter_state), 32'(S_IDLE));
    check("rp_set_stb", 32'(set_bus.stb_o), 0);
    check("rp_set_adr", set_bus.adr_o, 0);
    check("rp_brd_stb", 32'(brd_bus.stb_o), 0);
    check("rp_brd_we", 32'(brd_bus.we_o), 0);
    check("rp_brd_adr", brd_bus.adr_o, 0);
    check("rp_brd_dat", brd_bus.dat_o, 0);
    main_state = MENU;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rp_after_release", 32'(dut.planter_state), 32'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
